input_frame_buffer: RTL and testbench
=====================================

# input_frame_buffer

Ping-pong input frame buffer: the successor to the single-bank channel buffer at the front of the SNN datapath. It stores 16-bit input words carrying PACK = 16/DW packed samples into one of two banks. Meanwhile it streams the other bank out, one DW-bit sample per cycle, under a ready/valid handshake with backpressure. It keeps the host external access port, now bank-addressable, and adds overflow reporting and per-sample channel tagging.

## Interface
- CHANNELS, 128, samples per frame; must be a multiple of PACK.
- DW, 16, sample width; legal values are 16, 8 and 4. PACK = 16/DW (derived). WORDS = CHANNELS/PACK (derived).
- clk  in  1  clock; all logic is on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- in_valid  in  1  an input word is offered this cycle.
- in_data  in  16  packed input word. The most-significant lane is the lower channel index.
- in_ready  out  1  the block accepts in_data when in_valid and in_ready are both high.
- out_valid  out  1  a sample is presented.
- out_ready  in  1  the consumer accepts the sample.
- out_data  out  DW  signed sample.
- out_chan  out  clog2(CHANNELS)  channel index of out_data.
- out_last  out  1  out_data is channel CHANNELS-1.
- overflow  out  1  sticky flag: in_valid was seen while in_ready was low.
- ovf_clr  in  1  clears overflow.
- ext_en  in  1  host read request.
- ext_wren  in  1  host write request; takes precedence over ext_en.
- ext_bank  in  1  bank selected for host access.
- ext_addr  in  clog2(WORDS)  word address for host access.
- ext_wdata  in  16  host write data.
- ext_rdata  out  16  host read data.

## Operation
- Each bank has four states: EMPTY, FILLING, FULL and DRAINING. Two pointers, wbank and rbank, select the write and read banks; both reset to 0.
- Write side:
  - An accepted word goes to wbank at wptr; wptr increments.
  - When wptr reaches WORDS-1 and that word is accepted, wptr wraps to 0, wbank's state becomes FULL and wbank toggles.
  - in_ready = 0 while wbank is FULL or DRAINING, or while ext_en or ext_wren is high. Otherwise in_ready = 1.
- Read side:
  - When rbank is FULL it becomes DRAINING. The block then emits CHANNELS samples in lane order: word 0 MS lane first, through word WORDS-1 LS lane.
  - out_chan counts 0..CHANNELS-1.
  - After the out_last handshake, rbank becomes EMPTY and rbank toggles.
- Handshake rules:
  - Once out_valid is asserted, out_data, out_chan and out_last hold stable until out_ready is high.
  - out_valid never deasserts without a completed transfer, except on reset.
- External access:
  - A write stores ext_wdata at (ext_bank, ext_addr).
  - A read returns that word on ext_rdata one cycle later. ext_rdata holds its value until the next read.
  - While ext_en or ext_wren is high, the block fetches no new stream words. A sample already presented stays valid.
  - Bank state and pointers are not changed by host access. Writing a DRAINING bank is allowed and is not protected.
- overflow is set by in_valid && !in_ready. The offending word is discarded. If set and ovf_clr coincide, set wins.
- Simultaneous events: if the writer completes one bank in the same cycle the reader frees the other, both updates apply and in_ready = 1 on the next cycle.
- A DW=16 build has no lane mux; out_data is the full word.

## Timing
- Reset values: in_ready=1, out_valid=0, out_data=0, out_chan=0, out_last=0, overflow=0, ext_rdata=0, both banks EMPTY, wptr=0, read counters at 0.
- Asserting rst_n low mid-frame discards both banks' contents logically (states return to EMPTY). RAM contents are not cleared.
- Storage is two single-port 16 x WORDS RAMs (or one dual-port RAM), each with 1-cycle read latency.
- Latency: if the last word of a frame is accepted in cycle N and the read bank is idle, out_valid rises in cycle N+2.
- Throughput:
  - Sustained output is 1 sample per cycle while out_ready = 1.
  - Back-to-back frames have no bubble when the next bank is already FULL; a 2-entry prefetch is required for this.
  - Input rate is 1 word per cycle.
- in_ready is a registered function of the bank states, except for its combinational dependence on ext_en and ext_wren.

## Test plan
All scenarios use CHANNELS=8, DW=8 (PACK=2, WORDS=4) unless stated.

- Single frame: write 0x0102, 0x0304, 0x0506, 0x0708 with out_ready=1 -> out_data sequence 1..8, out_chan 0..7, out_last only on sample 8, first out_valid 2 cycles after the 4th write.
- Backpressure: write two frames (0x0102..0x0708, then 0x1112..0x1718) with out_ready=0 -> in_ready drops after word 8. A 9th word with in_valid=1 sets overflow and is discarded. Then raise out_ready -> 16 samples 1..8, 0x11..0x18 with no bubble between frames.
- Output stall: toggle out_ready randomly during a frame -> no sample lost or duplicated, and data stays stable while out_ready=0.
- External access: ext_wren bank 1, addr 2, 0xBEEF; then ext_en on the same address -> ext_rdata=0xBEEF one cycle after the read. in_ready=0 during both accesses, and an in-flight output sample is held.
- Reset mid-frame: rst_n low after 2 of 4 words, then write 4 fresh words -> exactly one frame of the fresh data is streamed, and overflow=0.
- DW=16 and DW=4 builds: words 0x1234... -> DW=4 emits nibbles 1,2,3,4 per word; DW=16 emits the words unchanged.

Source files
------------

// File: rtl/input_frame_buffer_if.sv
// Stream-side bundle of the ping-pong input frame buffer: the packed word
// input and the per-sample output, each with a ready/valid handshake.
interface input_frame_buffer_if #(
    parameter int CHANNELS = 128,
    parameter int DW       = 16
);
    localparam int CW = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;

    logic          in_valid;
    logic [15:0]   in_data;
    logic          in_ready;
    logic          out_valid;
    logic          out_ready;
    logic [DW-1:0] out_data;
    logic [CW-1:0] out_chan;
    logic          out_last;

    // producer/consumer side (testbench or upstream/downstream logic)
    modport master (
        output in_valid, in_data, out_ready,
        input  in_ready, out_valid, out_data, out_chan, out_last
    );

    // buffer side
    modport slave (
        input  in_valid, in_data, out_ready,
        output in_ready, out_valid, out_data, out_chan, out_last
    );
endinterface

// File: rtl/input_frame_buffer.sv
// Ping-pong input frame buffer: packed 16-bit words fill one bank while the
// other bank streams out one DW-bit sample per cycle with channel tags.
// A host port can read/write either bank word-wise; host access pauses the
// stream write side and the read prefetch.
//
// Bank states:
//   state      | meaning
//   B_EMPTY    | no data, ready for the writer
//   B_FILLING  | writer has stored part of a frame
//   B_FULL     | complete frame waiting for the reader
//   B_DRAINING | reader is fetching/emitting this frame
module input_frame_buffer #(
    parameter  int CHANNELS = 128,
    parameter  int DW       = 16,
    localparam int PACK     = 16 / DW,
    localparam int WORDS    = CHANNELS / PACK,
    localparam int WA       = (WORDS > 1) ? $clog2(WORDS) : 1,
    localparam int CW       = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
    input  logic                 i_clk,
    input  logic                 i_rst_n,
    input_frame_buffer_if.slave  stream,
    output logic                 o_overflow,
    input  logic                 i_ovf_clr,
    input  logic                 i_ext_en,
    input  logic                 i_ext_wren,
    input  logic                 i_ext_bank,
    input  logic [WA-1:0]        i_ext_addr,
    input  logic [15:0]          i_ext_wdata,
    output logic [15:0]          o_ext_rdata
);
    localparam int LW = (PACK > 1) ? $clog2(PACK) : 1;

    typedef enum logic [1:0] {
        B_EMPTY    = 2'd0,
        B_FILLING  = 2'd1,
        B_FULL     = 2'd2,
        B_DRAINING = 2'd3
    } bank_state_t;

    bank_state_t   r_bstate     [2];
    bank_state_t   w_bstate_nxt [2];
    logic          r_wbank, w_wbank_nxt;
    logic          r_ibank;            // bank the prefetch is reading from
    logic          r_rbank;            // bank whose samples are being emitted
    logic          r_wr_open, w_wr_open_nxt;
    logic [WA-1:0] r_wptr, r_raddr;
    logic [15:0]   r_mem [2][WORDS];
    logic [15:0]   r_fq [2];           // 2-entry word prefetch queue
    logic          r_fhead;
    logic [1:0]    r_fcnt;
    logic [CW-1:0] r_chan;
    logic          r_ovf;
    logic [15:0]   r_ext_rdata;

    logic          w_host, w_in_ready, w_wr_fire, w_wr_done;
    logic          w_out_valid, w_out_fire, w_lane_last, w_word_pop, w_frame_done;
    logic          w_issue, w_issue_done;
    logic [15:0]   w_head;
    logic [DW-1:0] w_out_data;

    assign w_host       = i_ext_en | i_ext_wren;
    assign w_in_ready   = r_wr_open & ~w_host;
    assign w_wr_fire    = stream.in_valid & w_in_ready;
    assign w_wr_done    = w_wr_fire & (r_wptr == WA'(WORDS - 1));
    assign w_out_valid  = (r_fcnt != 2'd0);
    assign w_out_fire   = w_out_valid & stream.out_ready;
    assign w_word_pop   = w_out_fire & w_lane_last;
    assign w_frame_done = w_out_fire & (r_chan == CW'(CHANNELS - 1));
    // Prefetch runs ahead across the bank boundary so a FULL next bank
    // streams without a bubble; the queue never holds more than two words.
    assign w_issue      = ~w_host & ((r_fcnt != 2'd2) | w_word_pop) &
                          ((r_bstate[r_ibank] == B_FULL) | (r_bstate[r_ibank] == B_DRAINING));
    assign w_issue_done = w_issue & (r_raddr == WA'(WORDS - 1));
    assign w_head       = r_fq[r_fhead];

    // Lane select: the sample lane is the low bits of the channel counter,
    // most-significant lane first.
    generate
        if (PACK == 1) begin : g_nolane
            assign w_out_data  = w_head;
            assign w_lane_last = 1'b1;
        end else begin : g_lane
            logic [LW-1:0] w_lane;
            logic [15:0]   w_shifted;
            assign w_lane      = r_chan[LW-1:0];
            assign w_shifted   = w_head << (w_lane * DW);
            assign w_out_data  = w_shifted[15 -: DW];
            assign w_lane_last = &w_lane;
        end
    endgenerate

    // Bank next-state: writer, prefetch start and frame release never touch
    // the same bank in one cycle, so all three updates can apply together.
    always_comb begin
        w_bstate_nxt[0] = r_bstate[0];
        w_bstate_nxt[1] = r_bstate[1];
        if (w_wr_fire)
            w_bstate_nxt[r_wbank] = w_wr_done ? B_FULL : B_FILLING;
        if (w_issue && (r_bstate[r_ibank] == B_FULL))
            w_bstate_nxt[r_ibank] = B_DRAINING;
        if (w_frame_done)
            w_bstate_nxt[r_rbank] = B_EMPTY;
        w_wbank_nxt   = r_wbank ^ w_wr_done;
        w_wr_open_nxt = (w_bstate_nxt[w_wbank_nxt] == B_EMPTY) ||
                        (w_bstate_nxt[w_wbank_nxt] == B_FILLING);
    end

    // Bank state register and registered write-side availability.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_bstate[0] <= B_EMPTY;
            r_bstate[1] <= B_EMPTY;
            r_wr_open   <= 1'b1;
        end else begin
            r_bstate[0] <= w_bstate_nxt[0];
            r_bstate[1] <= w_bstate_nxt[1];
            r_wr_open   <= w_wr_open_nxt;
        end
    end

    // Bank pointers and word addresses.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_wbank <= 1'b0;
            r_wptr  <= '0;
            r_ibank <= 1'b0;
            r_raddr <= '0;
            r_rbank <= 1'b0;
        end else begin
            r_wbank <= w_wbank_nxt;
            if (w_wr_fire)
                r_wptr <= w_wr_done ? '0 : r_wptr + 1'b1;
            if (w_issue) begin
                r_raddr <= w_issue_done ? '0 : r_raddr + 1'b1;
                r_ibank <= r_ibank ^ w_issue_done;
            end
            if (w_frame_done)
                r_rbank <= ~r_rbank;
        end
    end

    // Storage write port: host write wins; stream writes are blocked
    // anyway while the host is active.
    always_ff @(posedge i_clk) begin
        if (i_ext_wren)
            r_mem[i_ext_bank][i_ext_addr] <= i_ext_wdata;
        else if (w_wr_fire)
            r_mem[r_wbank][r_wptr] <= stream.in_data;
    end

    // Read port: prefetch into the word queue, or host read into ext_rdata.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_fq[0]     <= '0;
            r_fq[1]     <= '0;
            r_fhead     <= 1'b0;
            r_fcnt      <= 2'd0;
            r_ext_rdata <= '0;
        end else begin
            if (w_issue)
                r_fq[r_fhead ^ r_fcnt[0]] <= r_mem[r_ibank][r_raddr];
            else if (i_ext_en && !i_ext_wren)
                r_ext_rdata <= r_mem[i_ext_bank][i_ext_addr];
            r_fcnt  <= r_fcnt + 2'(w_issue) - 2'(w_word_pop);
            r_fhead <= r_fhead ^ w_word_pop;
        end
    end

    // Channel counter and sticky overflow (set beats clear).
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_chan <= '0;
            r_ovf  <= 1'b0;
        end else begin
            if (w_out_fire)
                r_chan <= w_frame_done ? '0 : r_chan + 1'b1;
            if (stream.in_valid && !w_in_ready)
                r_ovf <= 1'b1;
            else if (i_ovf_clr)
                r_ovf <= 1'b0;
        end
    end

    assign stream.in_ready  = w_in_ready;
    assign stream.out_valid = w_out_valid;
    assign stream.out_data  = w_out_data;
    assign stream.out_chan  = r_chan;
    assign stream.out_last  = (r_chan == CW'(CHANNELS - 1));
    assign o_overflow       = r_ovf;
    assign o_ext_rdata      = r_ext_rdata;
endmodule

// File: tb/tb_input_frame_buffer.sv
// Bench for input_frame_buffer: main build CHANNELS=8/DW=8 checked against a
// frame-level sample queue model, plus DW=4 and DW=16 builds checked with
// literal expectations.
module tb_input_frame_buffer;
    localparam int CH = 8;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    // main build: DW=8, PACK=2, WORDS=4
    input_frame_buffer_if #(.CHANNELS(CH), .DW(8)) m_if ();
    logic        m_ovf, m_ovf_clr, m_ext_en, m_ext_wren, m_ext_bank;
    logic [1:0]  m_ext_addr;
    logic [15:0] m_ext_wdata, m_ext_rdata;

    input_frame_buffer #(.CHANNELS(CH), .DW(8)) u_dut (
        .i_clk(clk), .i_rst_n(rst_n), .stream(m_if.slave),
        .o_overflow(m_ovf), .i_ovf_clr(m_ovf_clr),
        .i_ext_en(m_ext_en), .i_ext_wren(m_ext_wren), .i_ext_bank(m_ext_bank),
        .i_ext_addr(m_ext_addr), .i_ext_wdata(m_ext_wdata), .o_ext_rdata(m_ext_rdata)
    );

    // DW=4 build: PACK=4, WORDS=2
    input_frame_buffer_if #(.CHANNELS(CH), .DW(4)) q_if ();
    logic        q_ovf;
    logic [15:0] q_ext_rdata;
    logic        q_ext_addr;

    input_frame_buffer #(.CHANNELS(CH), .DW(4)) u_dut4 (
        .i_clk(clk), .i_rst_n(rst_n), .stream(q_if.slave),
        .o_overflow(q_ovf), .i_ovf_clr(1'b0),
        .i_ext_en(1'b0), .i_ext_wren(1'b0), .i_ext_bank(1'b0),
        .i_ext_addr(q_ext_addr), .i_ext_wdata(16'h0000), .o_ext_rdata(q_ext_rdata)
    );

    // DW=16 build: PACK=1, WORDS=8
    input_frame_buffer_if #(.CHANNELS(CH), .DW(16)) h_if ();
    logic        h_ovf;
    logic [15:0] h_ext_rdata;
    logic [2:0]  h_ext_addr;

    input_frame_buffer #(.CHANNELS(CH), .DW(16)) u_dut16 (
        .i_clk(clk), .i_rst_n(rst_n), .stream(h_if.slave),
        .o_overflow(h_ovf), .i_ovf_clr(1'b0),
        .i_ext_en(1'b0), .i_ext_wren(1'b0), .i_ext_bank(1'b0),
        .i_ext_addr(h_ext_addr), .i_ext_wdata(16'h0000), .o_ext_rdata(h_ext_rdata)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- frame-level model of the main build ----------------
    typedef struct {
        logic [7:0] d;
        int         ch;
        bit         last;
    } samp_t;

    samp_t       exp_q[$];
    logic [15:0] wbuf[$];
    samp_t       cs;

    // A complete frame of CH/2 words becomes CH samples, high byte first.
    function automatic void model_push(input logic [15:0] w);
        samp_t s;
        wbuf.push_back(w);
        if (wbuf.size() == CH / 2) begin
            for (int i = 0; i < CH / 2; i++) begin
                for (int l = 0; l < 2; l++) begin
                    s.d    = 8'((wbuf[i] >> (8 * (1 - l))) & 16'h00FF);
                    s.ch   = 2 * i + l;
                    s.last = (s.ch == CH - 1);
                    exp_q.push_back(s);
                end
            end
            wbuf.delete();
        end
    endfunction

    // Output compare: every handshake against the model, every stall for stability.
    logic       hold;
    logic [7:0] hd;
    logic [2:0] hc;
    logic       hl;
    always @(negedge clk) begin
        if (!rst_n) begin
            hold = 1'b0;
        end else begin
            if (hold) begin
                chk("hold_valid", m_if.out_valid, 1'b1);
                chk("hold_data",  m_if.out_data, hd);
                chk("hold_chan",  m_if.out_chan, hc);
                chk("hold_last",  m_if.out_last, hl);
            end
            hold = 1'b0;
            if (m_if.out_valid) begin
                if (m_if.out_ready) begin
                    if (exp_q.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL extra_sample: got data 0x%0h chan %0d, expected no sample", m_if.out_data, m_if.out_chan);
                    end else begin
                        cs = exp_q.pop_front();
                        chk("out_data", m_if.out_data, cs.d);
                        chk("out_chan", m_if.out_chan, cs.ch);
                        chk("out_last", m_if.out_last, cs.last);
                    end
                end else begin
                    hold = 1'b1;
                    hd   = m_if.out_data;
                    hc   = m_if.out_chan;
                    hl   = m_if.out_last;
                end
            end
        end
    end

    // Collectors for the DW=4 and DW=16 builds.
    logic [3:0]  got4[$];
    logic [2:0]  gch4[$];
    logic [15:0] got16[$];
    logic [2:0]  gch16[$];
    always @(negedge clk) begin
        if (rst_n && q_if.out_valid && q_if.out_ready) begin
            got4.push_back(q_if.out_data);
            gch4.push_back(q_if.out_chan);
        end
        if (rst_n && h_if.out_valid && h_if.out_ready) begin
            got16.push_back(h_if.out_data);
            gch16.push_back(h_if.out_chan);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic put_word(input logic [15:0] w, input logic exp_rdy);
        m_if.in_valid = 1'b1;
        m_if.in_data  = w;
        @(negedge clk);
        chk("in_ready", m_if.in_ready, exp_rdy);
        if (exp_rdy) model_push(w);
        tick();
        m_if.in_valid = 1'b0;
    endtask

    task automatic wait_drain();
        int k = 0;
        while (exp_q.size() != 0 && k < 300) begin
            @(negedge clk);
            k++;
        end
        chk("drain_left", exp_q.size(), 0);
        tick();
        @(negedge clk);
        chk("no_extra", m_if.out_valid, 1'b0);
        tick();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: time limit reached before end of test");
        $fatal(1);
    end

    logic [31:0] pat;

    initial begin
        rst_n        = 1'b0;
        m_if.in_valid = 1'b0; m_if.in_data = '0; m_if.out_ready = 1'b0;
        m_ovf_clr = 1'b0; m_ext_en = 1'b0; m_ext_wren = 1'b0; m_ext_bank = 1'b0;
        m_ext_addr = '0; m_ext_wdata = '0;
        q_if.in_valid = 1'b0; q_if.in_data = '0; q_if.out_ready = 1'b1; q_ext_addr = 1'b0;
        h_if.in_valid = 1'b0; h_if.in_data = '0; h_if.out_ready = 1'b1; h_ext_addr = '0;
        pat = 32'b1011_0011_1000_1101_0110_0101_1100_1001;
        hold = 1'b0;

        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;

        // reset values
        @(negedge clk);
        chk("rst_in_ready",  m_if.in_ready, 1'b1);
        chk("rst_out_valid", m_if.out_valid, 1'b0);
        chk("rst_out_data",  m_if.out_data, 8'h00);
        chk("rst_out_chan",  m_if.out_chan, 3'd0);
        chk("rst_out_last",  m_if.out_last, 1'b0);
        chk("rst_overflow",  m_ovf, 1'b0);
        chk("rst_ext_rdata", m_ext_rdata, 16'h0000);
        tick();

        // single frame, latency of first sample (bank 0)
        m_if.out_ready = 1'b1;
        for (int i = 0; i < 4; i++) put_word(16'h0102 + 16'(i) * 16'h0202, 1'b1);
        @(negedge clk);
        chk("lat_n1_valid", m_if.out_valid, 1'b0);
        @(negedge clk);
        chk("lat_n2_valid", m_if.out_valid, 1'b1);
        chk("first_data",   m_if.out_data, 8'h01);
        chk("first_chan",   m_if.out_chan, 3'd0);
        wait_drain();

        // backpressure: two frames (banks 1 then 0), a discarded 9th word
        m_if.out_ready = 1'b0;
        for (int i = 0; i < 4; i++) put_word(16'h0102 + 16'(i) * 16'h0202, 1'b1);
        for (int i = 0; i < 4; i++) put_word(16'h1112 + 16'(i) * 16'h0202, 1'b1);
        put_word(16'h9999, 1'b0);
        @(negedge clk);
        chk("ovf_set", m_ovf, 1'b1);
        tick();
        m_if.out_ready = 1'b1;
        for (int i = 0; i < 16; i++) begin
            @(negedge clk);
            chk("no_bubble", m_if.out_valid, 1'b1);
        end
        wait_drain();

        // overflow clear, then set-wins-over-clear while host access blocks input
        m_ovf_clr = 1'b1;
        tick();
        m_ovf_clr = 1'b0;
        @(negedge clk);
        chk("ovf_clr", m_ovf, 1'b0);
        tick();
        m_if.in_valid = 1'b1; m_if.in_data = 16'h7777; m_ext_en = 1'b1; m_ovf_clr = 1'b1;
        @(negedge clk);
        chk("host_blocks_ready", m_if.in_ready, 1'b0);
        tick();
        m_if.in_valid = 1'b0; m_ext_en = 1'b0; m_ovf_clr = 1'b0;
        @(negedge clk);
        chk("ovf_set_wins", m_ovf, 1'b1);
        tick();
        m_ovf_clr = 1'b1;
        tick();
        m_ovf_clr = 1'b0;

        // output stall with a fixed out_ready pattern (bank 1)
        m_if.out_ready = 1'b0;
        for (int i = 0; i < 4; i++) put_word(16'h3132 + 16'(i) * 16'h0202, 1'b1);
        for (int c = 0; c < 40; c++) begin
            m_if.out_ready = pat[c % 32];
            tick();
        end
        m_if.out_ready = 1'b1;
        wait_drain();

        // host access with a sample held at the output (frame in bank 0)
        m_if.out_ready = 1'b0;
        for (int i = 0; i < 4; i++) put_word(16'h2122 + 16'(i) * 16'h0202, 1'b1);
        m_ext_wren = 1'b1; m_ext_bank = 1'b1; m_ext_addr = 2'd2; m_ext_wdata = 16'hBEEF;
        @(negedge clk);
        chk("ext_wr_in_ready", m_if.in_ready, 1'b0);
        tick();
        m_ext_wren = 1'b0; m_ext_en = 1'b1;
        @(negedge clk);
        chk("ext_rd_in_ready", m_if.in_ready, 1'b0);
        tick();
        m_ext_en = 1'b0;
        @(negedge clk);
        chk("ext_rdata", m_ext_rdata, 16'hBEEF);
        tick();
        @(negedge clk);
        chk("ext_rdata_hold", m_ext_rdata, 16'hBEEF);
        chk("ext_out_held",   m_if.out_valid, 1'b1);
        tick();
        m_ext_en = 1'b1; m_ext_bank = 1'b0; m_ext_addr = 2'd1;
        tick();
        m_ext_en = 1'b0;
        @(negedge clk);
        chk("ext_rdata_frame", m_ext_rdata, 16'h2324);
        tick();
        m_if.out_ready = 1'b1;
        wait_drain();

        // reset mid-frame, with overflow set beforehand
        put_word(16'h4142, 1'b1);
        put_word(16'h4344, 1'b1);
        m_if.in_valid = 1'b1; m_ext_en = 1'b1;
        tick();
        m_if.in_valid = 1'b0; m_ext_en = 1'b0;
        @(negedge clk);
        chk("pre_rst_ovf", m_ovf, 1'b1);
        tick();
        rst_n = 1'b0;
        wbuf.delete();
        exp_q.delete();
        tick();
        tick();
        rst_n = 1'b1;
        @(negedge clk);
        chk("mid_rst_ovf",       m_ovf, 1'b0);
        chk("mid_rst_in_ready",  m_if.in_ready, 1'b1);
        chk("mid_rst_out_valid", m_if.out_valid, 1'b0);
        tick();
        for (int i = 0; i < 4; i++) put_word(16'h5152 + 16'(i) * 16'h0202, 1'b1);
        wait_drain();
        chk("post_rst_ovf", m_ovf, 1'b0);

        // DW=4 build: nibbles in MS-first order
        q_if.in_valid = 1'b1; q_if.in_data = 16'h1234;
        @(negedge clk);
        chk("d4_in_ready", q_if.in_ready, 1'b1);
        tick();
        q_if.in_data = 16'h5678;
        tick();
        q_if.in_valid = 1'b0;
        // DW=16 build: words pass through unchanged
        for (int i = 0; i < 8; i++) begin
            h_if.in_valid = 1'b1;
            h_if.in_data  = 16'hA000 + 16'(i) * 16'h0111;
            @(negedge clk);
            chk("d16_in_ready", h_if.in_ready, 1'b1);
            tick();
        end
        h_if.in_valid = 1'b0;
        for (int k = 0; k < 100 && (got4.size() < 8 || got16.size() < 8); k++) tick();
        repeat (4) tick();
        chk("d4_count",  got4.size(), 8);
        chk("d16_count", got16.size(), 8);
        for (int i = 0; i < 8 && i < got4.size(); i++) begin
            chk("d4_data", got4[i], i + 1);
            chk("d4_chan", gch4[i], i);
        end
        for (int i = 0; i < 8 && i < got16.size(); i++) begin
            chk("d16_data", got16[i], 16'hA000 + 16'(i) * 16'h0111);
            chk("d16_chan", gch16[i], i);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
